// File: rtl/therm_encoder_seq.sv
// -----------------------------------------------------------------------------
// therm_encoder_seq
//
// Sequential thermometer-to-binary encoder. A 16-bit thermometer code is
// accepted over a valid/ready handshake. The block then scans it LSB-first,
// one bit per clock, and returns the run length of contiguous ones from
// bit 0, together with two error flags, over a second valid/ready handshake.
// It sits on the readback path of the 16-bit shift register and recovers the
// fill level from a captured thermometer word.
//
// Ports:
//   clk         single clock; all state changes on the rising edge
//   rst         synchronous, active-high reset
//   in_valid    din carries a code to be encoded
//   in_ready    block is idle and can accept a code
//   din         thermometer code (WIDTH bits)
//   out_valid   result (dout / err_*) is valid
//   out_ready   consumer accepts the result
//   dout        run length of ones from bit 0, saturated to WIDTH-1
//   err_bubble  a one was seen above the first zero (non-thermometer code)
//   err_full    every bit set (run length WIDTH, dout saturated)
//
// Timing: a code accepted on edge E0 is scanned on edges E1..E16. The result
// is registered on E16, so out_valid is high right after E16. The handshake
// edge returns to IDLE, which makes the minimum accept-to-accept spacing
// 18 edges.
// -----------------------------------------------------------------------------
module therm_encoder_seq #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    dout,
    output logic             err_bubble,
    output logic             err_full
);

    // The run counter needs one extra bit so that an all-ones code (run of
    // WIDTH) can be told apart from a run of WIDTH-1.
    localparam int RW = CW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State
    // ---------------------------------------------------------------------
    state_t           state_q,      state_d;
    logic [WIDTH-1:0] shreg_q,      shreg_d;
    logic [CW-1:0]    bit_cnt_q,    bit_cnt_d;
    logic [RW-1:0]    run_q,        run_d;
    logic             seen_zero_q,  seen_zero_d;
    logic             bubble_q,     bubble_d;
    logic [CW-1:0]    dout_q,       dout_d;
    logic             err_bubble_q, err_bubble_d;
    logic             err_full_q,   err_full_d;

    // ---------------------------------------------------------------------
    // One scan step: the effect of examining shreg_q[0] this cycle.
    // Computed unconditionally; only used while in SCAN.
    // ---------------------------------------------------------------------
    logic          scan_bit;
    logic [RW-1:0] run_step;
    logic          bubble_step;
    logic          seen_zero_step;
    logic          last_bit;
    logic          full_step;
    logic [CW-1:0] dout_step;

    always_comb begin
        scan_bit       = shreg_q[0];
        // Ones only extend the run until the first zero has been seen.
        run_step       = run_q + RW'(scan_bit & ~seen_zero_q);
        // A one after a zero means the code was not a thermometer code.
        bubble_step    = bubble_q | (scan_bit & seen_zero_q);
        seen_zero_step = seen_zero_q | ~scan_bit;
        last_bit       = (bit_cnt_q == CW'(WIDTH - 1));
        full_step      = (run_step == RW'(WIDTH));
        // Saturate: a full run of WIDTH reports WIDTH-1 with err_full set.
        dout_step      = full_step ? {CW{1'b1}} : run_step[CW-1:0];
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        run_d        = run_q;
        seen_zero_d  = seen_zero_q;
        bubble_d     = bubble_q;
        dout_d       = dout_q;
        err_bubble_d = err_bubble_q;
        err_full_d   = err_full_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d     = din;
                    bit_cnt_d   = '0;
                    run_d       = '0;
                    seen_zero_d = 1'b0;
                    bubble_d    = 1'b0;
                    state_d     = SCAN;
                end
            end

            SCAN: begin
                // No early exit: every bit is examined so that bubbles in
                // the upper bits are always detected.
                shreg_d     = {1'b0, shreg_q[WIDTH-1:1]};
                bit_cnt_d   = bit_cnt_q + CW'(1);
                run_d       = run_step;
                seen_zero_d = seen_zero_step;
                bubble_d    = bubble_step;
                if (last_bit) begin
                    // Result registers take the final values on the same
                    // edge that examines the top bit.
                    dout_d       = dout_step;
                    err_bubble_d = bubble_step;
                    err_full_d   = full_step;
                    state_d      = DONE;
                end
            end

            DONE: begin
                // Hold the result until the consumer takes it. The output
                // registers are left untouched so they keep their values
                // through IDLE until the next result.
                if (out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_cnt_q    <= '0;
            run_q        <= '0;
            seen_zero_q  <= 1'b0;
            bubble_q     <= 1'b0;
            dout_q       <= '0;
            err_bubble_q <= 1'b0;
            err_full_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_cnt_q    <= bit_cnt_d;
            run_q        <= run_d;
            seen_zero_q  <= seen_zero_d;
            bubble_q     <= bubble_d;
            dout_q       <= dout_d;
            err_bubble_q <= err_bubble_d;
            err_full_q   <= err_full_d;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign dout       = dout_q;
    assign err_bubble = err_bubble_q;
    assign err_full   = err_full_q;

endmodule

// File: tb/tb_therm_encoder_seq.sv
// -----------------------------------------------------------------------------
// tb_therm_encoder_seq
//
// Directed bench for therm_encoder_seq. Inputs are driven and outputs are
// sampled on the falling edge; the DUT acts on the rising edge. Expected
// values are hand-computed per vector.
// -----------------------------------------------------------------------------
module tb_therm_encoder_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] din;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  dout;
    logic        err_bubble;
    logic        err_full;

    int n_checks;
    int n_fail;

    therm_encoder_seq #(
        .WIDTH (16),
        .CW    (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .din        (din),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .dout       (dout),
        .err_bubble (err_bubble),
        .err_full   (err_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; return at the following falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    // Full transaction with out_ready=1: accept on E0, check out_valid low
    // through E15, result after E16, back to IDLE after E17.
    task automatic run_code(input logic [15:0] code, input logic [3:0] exp_dout,
                            input logic exp_bub, input logic exp_full);
        chk("pre_in_ready", 16'(in_ready), 16'd1);
        din       = code;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();                                     // after E0
        in_valid = 1'b0;
        din      = 16'h0000;
        chk("acc_in_ready", 16'(in_ready), 16'd0);
        for (int i = 1; i <= 15; i++) step();       // after E15
        chk("lat_out_valid_e15", 16'(out_valid), 16'd0);
        step();                                     // after E16
        chk("res_out_valid", 16'(out_valid), 16'd1);
        chk("res_dout", 16'(dout), 16'(exp_dout));
        chk("res_err_bubble", 16'(err_bubble), 16'(exp_bub));
        chk("res_err_full", 16'(err_full), 16'(exp_full));
        step();                                     // after E17 (handshake)
        chk("post_out_valid", 16'(out_valid), 16'd0);
        chk("post_in_ready", 16'(in_ready), 16'd1);
        $display("txn din=%04h dout=%0d bubble=%0b full=%0b (exp %0d %0b %0b)",
                 code, dout, err_bubble, err_full, exp_dout, exp_bub, exp_full);
    endtask

    initial begin
        logic [7:0]  cnt8;
        logic [15:0] code;

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din       = 16'h0000;

        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 16'(in_ready), 16'd1);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_dout", 16'(dout), 16'd0);
        chk("rst_err_bubble", 16'(err_bubble), 16'd0);
        chk("rst_err_full", 16'(err_full), 16'd0);

        // All-zero code is legal
        run_code(16'h0000, 4'd0, 1'b0, 1'b0);

        // Sweep of valid thermometer codes, back-to-back
        for (int k = 0; k < 16; k++) begin
            code = 16'((32'd1 << k) - 32'd1);
            run_code(code, 4'(k), 1'b0, 1'b0);
        end

        // Codes from the decoder driven by an 8-bit cycling counter
        cnt8 = 8'hFA;
        for (int j = 0; j < 10; j++) begin
            code = 16'((32'd1 << cnt8[3:0]) - 32'd1);
            run_code(code, cnt8[3:0], 1'b0, 1'b0);
            cnt8 = cnt8 + 8'd3;
        end

        // Boundary and error codes
        run_code(16'h7FFF, 4'd15, 1'b0, 1'b0);
        run_code(16'h00F5, 4'd1,  1'b1, 1'b0);
        run_code(16'h8000, 4'd0,  1'b1, 1'b0);
        run_code(16'h0003, 4'd2,  1'b0, 1'b0);
        run_code(16'hFFFF, 4'd15, 1'b0, 1'b1);

        // Reset mid-scan at bit counter 7 (edge E8)
        din      = 16'h00FF;
        in_valid = 1'b1;
        step();                                     // after E0
        in_valid = 1'b0;
        for (int i = 1; i <= 7; i++) step();        // after E7
        rst = 1'b1;
        step();                                     // after E8 (reset edge)
        rst = 1'b0;
        chk("abort_in_ready", 16'(in_ready), 16'd1);
        chk("abort_out_valid", 16'(out_valid), 16'd0);
        chk("abort_dout", 16'(dout), 16'd0);
        chk("abort_err_full", 16'(err_full), 16'd0);
        chk("abort_err_bubble", 16'(err_bubble), 16'd0);
        for (int i = 0; i < 12; i++) step();        // past where E16 would be
        chk("abort_no_result", 16'(out_valid), 16'd0);
        $display("txn aborted din=00ff in_ready=%0b out_valid=%0b dout=%0d",
                 in_ready, out_valid, dout);
        run_code(16'h0007, 4'd3, 1'b0, 1'b0);

        // Backpressure
        din       = 16'h001F;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();                                     // after E0
        in_valid = 1'b0;
        for (int i = 1; i <= 16; i++) step();       // after E16
        chk("bp_out_valid", 16'(out_valid), 16'd1);
        chk("bp_dout", 16'(dout), 16'd5);
        for (int i = 0; i < 5; i++) begin
            din      = 16'hFFFF;
            in_valid = 1'b1;
            step();
            chk("bp_hold_out_valid", 16'(out_valid), 16'd1);
            chk("bp_hold_dout", 16'(dout), 16'd5);
            chk("bp_hold_in_ready", 16'(in_ready), 16'd0);
            chk("bp_hold_err_full", 16'(err_full), 16'd0);
        end
        in_valid  = 1'b0;
        din       = 16'h0000;
        out_ready = 1'b1;
        step();                                     // handshake edge
        chk("bp_release_out_valid", 16'(out_valid), 16'd0);
        chk("bp_release_in_ready", 16'(in_ready), 16'd1);
        chk("bp_release_dout_hold", 16'(dout), 16'd5);
        $display("txn backpressure din=001f dout=%0d out_valid=%0b in_ready=%0b",
                 dout, out_valid, in_ready);

        // The ignored in_valid during DONE must not have started a scan
        step();
        chk("bp_no_spurious_scan", 16'(in_ready), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
